// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
// Optional statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int INDEX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t                state, state_nx;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic [31:0]           done_data;

    logic [INDEX_BITS-1:0] idx, lat_idx;
    logic [TAG_BITS-1:0]   tag, lat_tag;
    logic                  is_load, is_store, line_hit;
    logic                  start_fetch, start_write, load_hit, ack_take;
    logic                  unused_addr_bits;

    assign idx      = addr[INDEX_BITS+1:2];
    assign tag      = addr[31:INDEX_BITS+2];
    // The registered request address doubles as the latched copy of the access.
    assign lat_idx  = mem_addr[INDEX_BITS+1:2];
    assign lat_tag  = mem_addr[31:INDEX_BITS+2];
    assign is_store = mem_write;
    assign is_load  = mem_read && !mem_write;
    assign line_hit = valid[idx] && (tag_mem[idx] == tag);
    assign ack_take = mem_req && mem_ack && ((state == FETCH) || (state == WRITE));
    assign unused_addr_bits = ^addr[1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx    = state;
        hit         = 1'b0;
        rdata       = data_mem[idx];
        start_fetch = 1'b0;
        start_write = 1'b0;
        load_hit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_store) begin
                    start_write = 1'b1;
                    state_nx    = WRITE;
                end else if (is_load && !line_hit) begin
                    start_fetch = 1'b1;
                    state_nx    = FETCH;
                end else begin
                    hit      = 1'b1;
                    load_hit = is_load;
                end
            end
            FETCH: if (ack_take) state_nx = DONE;
            WRITE: if (ack_take) state_nx = DONE;
            DONE: begin
                hit      = 1'b1;
                rdata    = done_data;
                state_nx = IDLE;
            end
        endcase
        if (!rst_n) hit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata;
        end else if (start_fetch) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {addr[31:2], 2'b00};
        end else if (ack_take) begin
            mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                         valid          <= '0;
        else if (ack_take && state == FETCH) valid[lat_idx] <= 1'b1;
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && ack_take) begin
            if (state == FETCH) begin
                tag_mem[lat_idx]  <= lat_tag;
                data_mem[lat_idx] <= mem_rdata;
                done_data         <= mem_rdata;
            end else if (valid[lat_idx] && (tag_mem[lat_idx] == lat_tag)) begin
                data_mem[lat_idx] <= mem_wdata;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (load_hit)    hits_q   <= hits_q + 32'd1;
            if (start_fetch) misses_q <= misses_q + 32'd1;
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: misses, hits, eviction, stores, reset abort, stats.
// Expected values are hand-computed for the default INDEX_BITS=5 geometry.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] rdata;
    logic        hit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;

    int vectors = 0;
    int miscompares = 0;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int LOAD  = 0;
    localparam int STORE = 1;
    localparam int BOTH  = 2;

    dcache_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .wdata       (wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .rdata       (rdata),
        .hit         (hit),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one access; the memory responder acks on request cycle k (k=0: first cycle).
    task automatic access(input int mode, input logic [31:0] a, input logic [31:0] wd,
                          input int k, input logic [31:0] rd_data,
                          output int stall, output logic [31:0] rd_out,
                          output logic [31:0] req_addr, output logic req_we,
                          output logic [31:0] req_wdata, output bit saw_req,
                          output bit unstable);
        int req_cnt;
        req_cnt = 0; stall = 0; saw_req = 0; unstable = 0;
        req_addr = '1; req_we = 1'bx; req_wdata = '1;
        @(negedge clk);
        addr = a; wdata = wd;
        mem_read  = (mode != STORE);
        mem_write = (mode != LOAD);
        #1;
        while (!hit && stall < 50) begin
            if (mem_req) begin
                if (!saw_req) begin
                    req_addr = mem_addr; req_we = mem_we; req_wdata = mem_wdata;
                end else if (mem_addr !== req_addr || mem_we !== req_we || mem_wdata !== req_wdata) begin
                    unstable = 1;
                end
                saw_req   = 1;
                mem_ack   = (req_cnt == k);
                mem_rdata = (req_cnt == k) ? rd_data : 32'h0;
                req_cnt++;
            end
            stall++;
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
        end
        rd_out = rdata;
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        if (mem_req) saw_req = 1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        vectors++; if (hit !== 1'b0) begin miscompares++; $display("FAIL rst_hit: got %b want 0", hit); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        vectors++; if (perf_hits !== 32'h0) begin miscompares++; $display("FAIL rst_perf_hits: got %0d want 0", perf_hits); end
        vectors++; if (perf_misses !== 32'h0) begin miscompares++; $display("FAIL rst_perf_misses: got %0d want 0", perf_misses); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL idle_hit: got %b want 1", hit); end
    endtask

    task automatic test_cold_miss();
        int st; logic [31:0] rd, ra, rw; logic we; bit sr, us;
        access(LOAD, 32'h40, 32'h0, 3, 32'hDEADBEEF, st, rd, ra, we, rw, sr, us);
        vectors++; if (ra !== 32'h40) begin miscompares++; $display("FAIL cold_addr: got %h want 00000040", ra); end
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL cold_we: got %b want 0", we); end
        vectors++; if (st !== 5) begin miscompares++; $display("FAIL cold_stall: got %0d want 5", st); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL cold_rdata: got %h want deadbeef", rd); end
        vectors++; if (us !== 1'b0) begin miscompares++; $display("FAIL cold_stable: got %b want 0", us); end
        access(LOAD, 32'h40, 32'h0, 0, 32'h0, st, rd, ra, we, rw, sr, us);
        vectors++; if (st !== 0) begin miscompares++; $display("FAIL rehit_stall: got %0d want 0", st); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rehit_rdata: got %h want deadbeef", rd); end
        vectors++; if (sr !== 1'b0) begin miscompares++; $display("FAIL rehit_req: got %b want 0", sr); end
    endtask

    task automatic test_conflict();
        int st; logic [31:0] rd, ra, rw; logic we; bit sr, us;
        do_reset();
        access(LOAD, 32'h40, 32'h0, 0, 32'h11111111, st, rd, ra, we, rw, sr, us);
        vectors++; if (st !== 2) begin miscompares++; $display("FAIL conf_fill_stall: got %0d want 2", st); end
        access(LOAD, 32'hC0, 32'h0, 1, 32'h22222222, st, rd, ra, we, rw, sr, us);
        vectors++; if (st !== 3) begin miscompares++; $display("FAIL conf_evict_stall: got %0d want 3", st); end
        vectors++; if (ra !== 32'hC0) begin miscompares++; $display("FAIL conf_evict_addr: got %h want 000000c0", ra); end
        vectors++; if (rd !== 32'h22222222) begin miscompares++; $display("FAIL conf_evict_rdata: got %h want 22222222", rd); end
        access(LOAD, 32'h40, 32'h0, 0, 32'h33333333, st, rd, ra, we, rw, sr, us);
        vectors++; if (st !== 2) begin miscompares++; $display("FAIL conf_refetch_stall: got %0d want 2", st); end
        vectors++; if (ra !== 32'h40) begin miscompares++; $display("FAIL conf_refetch_addr: got %h want 00000040", ra); end
        vectors++; if (rd !== 32'h33333333) begin miscompares++; $display("FAIL conf_refetch_rdata: got %h want 33333333", rd); end
    endtask

    task automatic test_store_hit();
        int st; logic [31:0] rd, ra, rw; logic we; bit sr, us;
        access(STORE, 32'h40, 32'h12345678, 2, 32'h0, st, rd, ra, we, rw, sr, us);
        vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL sth_we: got %b want 1", we); end
        vectors++; if (rw !== 32'h12345678) begin miscompares++; $display("FAIL sth_wdata: got %h want 12345678", rw); end
        vectors++; if (ra !== 32'h40) begin miscompares++; $display("FAIL sth_addr: got %h want 00000040", ra); end
        vectors++; if (st !== 4) begin miscompares++; $display("FAIL sth_stall: got %0d want 4", st); end
        vectors++; if (us !== 1'b0) begin miscompares++; $display("FAIL sth_stable: got %b want 0", us); end
        access(LOAD, 32'h40, 32'h0, 0, 32'h0, st, rd, ra, we, rw, sr, us);
        vectors++; if (st !== 0) begin miscompares++; $display("FAIL sth_load_stall: got %0d want 0", st); end
        vectors++; if (rd !== 32'h12345678) begin miscompares++; $display("FAIL sth_load_rdata: got %h want 12345678", rd); end
        vectors++; if (sr !== 1'b0) begin miscompares++; $display("FAIL sth_load_req: got %b want 0", sr); end
    endtask

    task automatic test_store_miss();
        int st; logic [31:0] rd, ra, rw; logic we; bit sr, us;
        access(STORE, 32'h82, 32'h55AA55AA, 0, 32'h0, st, rd, ra, we, rw, sr, us);
        vectors++; if (ra !== 32'h80) begin miscompares++; $display("FAIL stm_addr: got %h want 00000080", ra); end
        vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL stm_we: got %b want 1", we); end
        vectors++; if (rw !== 32'h55AA55AA) begin miscompares++; $display("FAIL stm_wdata: got %h want 55aa55aa", rw); end
        vectors++; if (st !== 2) begin miscompares++; $display("FAIL stm_stall: got %0d want 2", st); end
        access(LOAD, 32'h80, 32'h0, 0, 32'h80808080, st, rd, ra, we, rw, sr, us);
        vectors++; if (st !== 2) begin miscompares++; $display("FAIL stm_load_stall: got %0d want 2", st); end
        vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL stm_load_we: got %b want 0", we); end
        vectors++; if (rd !== 32'h80808080) begin miscompares++; $display("FAIL stm_load_rdata: got %h want 80808080", rd); end
        access(BOTH, 32'h40, 32'hCAFEF00D, 1, 32'h0, st, rd, ra, we, rw, sr, us);
        vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL both_we: got %b want 1", we); end
        vectors++; if (rw !== 32'hCAFEF00D) begin miscompares++; $display("FAIL both_wdata: got %h want cafef00d", rw); end
        vectors++; if (st !== 3) begin miscompares++; $display("FAIL both_stall: got %0d want 3", st); end
        access(LOAD, 32'h40, 32'h0, 0, 32'h0, st, rd, ra, we, rw, sr, us);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL both_load_rdata: got %h want cafef00d", rd); end
        vectors++; if (sr !== 1'b0) begin miscompares++; $display("FAIL both_load_req: got %b want 0", sr); end
    endtask

    task automatic test_reset_mid_fetch();
        int st; logic [31:0] rd, ra, rw; logic we; bit sr, us;
        @(negedge clk);
        addr = 32'h104; mem_read = 1'b1;
        @(negedge clk); #1;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rmf_req_up: got %b want 1", mem_req); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rmf_req_drop: got %b want 0", mem_req); end
        vectors++; if (hit !== 1'b0) begin miscompares++; $display("FAIL rmf_hit_in_rst: got %b want 0", hit); end
        rst_n = 1'b1; mem_read = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rmf_late_ack_req: got %b want 0", mem_req); end
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL rmf_late_ack_hit: got %b want 1", hit); end
        access(LOAD, 32'h104, 32'h0, 0, 32'h01040104, st, rd, ra, we, rw, sr, us);
        vectors++; if (st !== 2) begin miscompares++; $display("FAIL rmf_reload_stall: got %0d want 2", st); end
        vectors++; if (rd !== 32'h01040104) begin miscompares++; $display("FAIL rmf_reload_rdata: got %h want 01040104", rd); end
    endtask

    task automatic test_stats();
        int st; logic [31:0] rd, ra, rw; logic we; bit sr, us;
        logic [31:0] exp_h, exp_m;
        do_reset();
        access(LOAD, 32'h40, 32'h0, 0, 32'h77777777, st, rd, ra, we, rw, sr, us);
        for (int i = 0; i < 3; i++) begin
            access(LOAD, 32'h40, 32'h0, 0, 32'h0, st, rd, ra, we, rw, sr, us);
        end
        exp_h = STATS ? 32'd3 : 32'd0;
        exp_m = STATS ? 32'd1 : 32'd0;
        vectors++; if (perf_hits !== exp_h) begin miscompares++; $display("FAIL stats_hits: got %0d want %0d", perf_hits, exp_h); end
        vectors++; if (perf_misses !== exp_m) begin miscompares++; $display("FAIL stats_misses: got %0d want %0d", perf_misses, exp_m); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_store_hit();
        test_store_miss();
        test_reset_mid_fetch();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage. It consumes the EX/MEM register outputs: ALU result as address, RD2 as store data, and the memory read/write controls. It produces `hit`, which gates the EX/MEM and upstream pipeline registers: they advance only when `hit`=1. On a miss or a store, it runs a request/acknowledge transaction to main memory and holds `hit` low until the access completes.

## Interface
Parameters:
- `INDEX_BITS`, default 5: line index width; the cache has 2^INDEX_BITS lines of one 32-bit word each.
- `TAG_BITS`, fixed at 30-INDEX_BITS: derived, not overridable.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1: single rising-edge clock.
- `rst_n`  in  1: synchronous active-low reset.
- `addr`  in  32: byte address from ALU result; bits [1:0] ignored.
- `wdata`  in  32: store data (RD2).
- `mem_read`  in  1: load request.
- `mem_write`  in  1: store request; has priority if both are asserted.
- `rdata`  out  32: load data.
- `hit`  out  1: access complete / no stall.
- `mem_req`  out  1: memory request, registered.
- `mem_we`  out  1: 1 = memory write, registered.
- `mem_addr`  out  32: word-aligned address, registered, {addr[31:2],2'b00}.
- `mem_wdata`  out  32: store data, registered.
- `mem_rdata`  in  32: refill data, valid with `mem_ack`.
- `mem_ack`  in  1: one-cycle completion pulse.
- `perf_hits`, `perf_misses`  out  32 each: statistics counters (see Configuration).

## Operation
- Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- Storage per line: valid bit, tag, 32-bit data.
- The FSM has four states: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - No access: `hit`=1.
  - Load with valid and matching tag: `hit`=1, `rdata`=line data in the same cycle.
  - Load miss: `hit`=0; latch address; go to FETCH with `mem_req`=1, `mem_we`=0.
  - Store: `hit`=0; latch address and data; go to WRITE with `mem_req`=1, `mem_we`=1.
- FETCH: `hit`=0. On `mem_ack`, write the line: valid=1, tag, data=`mem_rdata`. Drop `mem_req` and go to DONE.
- WRITE: `hit`=0. On `mem_ack`, update the line data only if it is valid and the tag matches (no allocate). Drop `mem_req` and go to DONE.
- DONE: `hit`=1 for exactly one cycle; `rdata`=data of the completed load (registered copy). Then go to IDLE. DONE prevents the stalled store from being re-issued.
- `addr`, `wdata`, `mem_read` and `mem_write` are ignored outside IDLE; the latched copies are used.
- `mem_ack` is ignored when `mem_req`=0.
- `rdata` is don't-care when there is no load, but it is deterministic: the line data at the current index.

## Timing
- Reset values:
  - State = IDLE; all valid bits = 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `hit`=0 while `rst_n`=0.
  - Counters = 0.
- `hit` and `rdata` are combinational from state, inputs and array; all memory-side outputs are registered.
- Load hit: 0 stall cycles.
- Load miss: `mem_req` rises on edge N+1 (request seen in cycle N). With the ack sampled at edge N+1+k (k≥0, k=0 meaning ack during the first request cycle), DONE occupies cycle N+2+k. Stall = k+2 cycles.
- Store: the same latency as a load miss, hit or miss.
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1.
- Reset during FETCH/WRITE: the transaction is abandoned and `mem_req`=0 after the edge. Memory must tolerate a dropped request; a late `mem_ack` is ignored.
- An index conflict evicts the old line silently. There is no dirty state, because every store is write-through.

## Configuration
- `DCACHE_STATS_EN` defined: `perf_hits` increments on each IDLE load hit; `perf_misses` increments on each FETCH entry. Both are 32-bit, wrap at 2^32, and are cleared by reset.
- `DCACHE_STATS_EN` undefined: both ports are tied to 0 and no counter flops exist. The port list is identical either way.

## Test plan
- Cold load miss:
  - Stimulus: after reset, load 0x40; memory acks after 3 cycles with 0xDEADBEEF.
  - Required: `mem_req` with `mem_addr`=0x40, `mem_we`=0; `hit`=0 for 5 cycles, then the DONE cycle has `rdata`=0xDEADBEEF.
  - Then load 0x40 again: `hit`=1 same cycle, no `mem_req`.
- Conflict eviction (INDEX_BITS=5):
  - Stimulus: load 0x40 (fill), then load 0xC0 (same index 16), then load 0x40.
  - Required: all three miss; the third refetches 0x40.
- Store hit:
  - Stimulus: with 0x40 cached, store 0x12345678 to 0x40.
  - Required: `mem_we`=1, `mem_wdata`=0x12345678; after ack and DONE, load 0x40 hits with 0x12345678 and no `mem_req`.
- Store miss, no allocate:
  - Stimulus: store 0x55AA55AA to 0x80 on a cold line, then load 0x80.
  - Required: the store reaches memory; the load misses.
  - Also: both `mem_read`=1 and `mem_write`=1 must be treated as a store.
- Reset mid-FETCH:
  - Stimulus: drive `rst_n`=0 one cycle into a FETCH; pulse `mem_ack` after release.
  - Required: `mem_req`=0 after the edge, the ack is ignored, and a load to the same address misses.
- Statistics with `DCACHE_STATS_EN`:
  - Stimulus: 1 miss, then 3 hits.
  - Required: `perf_misses`=1, `perf_hits`=3.
  - Without the macro, both read 0.
